// File: rtl/commit_trace_fifo_if.sv
// Commit-trace bus: per-cycle processor commit events in, trace records and statistics out.
// The FIFO uses the slave modport; the processor/consumer side uses master.
interface commit_trace_fifo_if;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Halt;
  logic [2:0]  WriteRegister;
  logic [15:0] WriteData;
  logic [15:0] MemAddress;
  logic [15:0] MemDataIn;
  logic [15:0] MemDataOut;
  logic        trc_valid;
  logic        trc_ready;
  logic [54:0] trc_data;
  logic        full;
  logic        overflow;
  logic        done;
  logic [31:0] inst_count;
  logic [31:0] cycle_count;
  logic [31:0] drop_count;

  modport master (
    output RegWrite, MemRead, MemWrite, Halt, WriteRegister,
           WriteData, MemAddress, MemDataIn, MemDataOut, trc_ready,
    input  trc_valid, trc_data, full, overflow, done,
           inst_count, cycle_count, drop_count
  );

  modport slave (
    input  RegWrite, MemRead, MemWrite, Halt, WriteRegister,
           WriteData, MemAddress, MemDataIn, MemDataOut, trc_ready,
    output trc_valid, trc_data, full, overflow, done,
           inst_count, cycle_count, drop_count
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: packs processor commit events into records and queues them for a consumer.
// Define TRACE_STATS_EN to build the inst/cycle/drop statistics counters; otherwise they read 0.
module commit_trace_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  commit_trace_fifo_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned REC_W  = 55;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {CAPTURE, HALTED, DONE} stateT;

  stateT            state, stateNext;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count, countNext;
  logic             overflowQ;
  logic             isEvent, accept, validC, fullC, pop, push, drop;
  logic [DATA_W-1:0] mdata;
  logic [REC_W-1:0] record;

  // Store data wins when both memory flags are set.
  always_comb begin
    mdata = '0;
    if (bus.MemWrite)     mdata = bus.MemDataIn;
    else if (bus.MemRead) mdata = bus.MemDataOut;
  end

  assign record  = {bus.Halt, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.WriteRegister,
                    bus.WriteData, bus.MemAddress, mdata};
  assign isEvent = bus.RegWrite | bus.MemRead | bus.MemWrite | bus.Halt;
  assign accept  = (state == CAPTURE) && isEvent;
  assign validC  = (count != '0);
  assign fullC   = (count == CNT_W'(DEPTH));
  assign pop     = validC && bus.trc_ready;
  assign push    = accept && (!fullC || pop);
  assign drop    = accept && fullC && !pop;

  assign countNext = count + CNT_W'(push) - CNT_W'(pop);

  // A halt moves on whether its record fit or was dropped; DONE once the queue is drained.
  always_comb begin
    stateNext = state;
    case (state)
      CAPTURE: if (isEvent && bus.Halt) stateNext = HALTED;
      HALTED:  if (countNext == '0)     stateNext = DONE;
      DONE:    stateNext = DONE;
      default: stateNext = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CAPTURE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflowQ <= 1'b0;
    end else begin
      state <= stateNext;
      count <= countNext;
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (drop) overflowQ <= 1'b1;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= record;
  end

  assign bus.trc_valid = validC;
  assign bus.trc_data  = validC ? mem[rdPtr] : '0;
  assign bus.full      = fullC;
  assign bus.overflow  = overflowQ;
  assign bus.done      = (state == DONE);

`ifdef TRACE_STATS_EN
  localparam int unsigned STAT_W = 32;

  logic [STAT_W-1:0] instCount, cycleCount, dropCount;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instCount  <= '0;
      cycleCount <= '0;
      dropCount  <= '0;
    end else begin
      if (state == CAPTURE) cycleCount <= cycleCount + STAT_W'(1);
      if (accept && (bus.Halt || bus.RegWrite || bus.MemWrite))
        instCount <= instCount + STAT_W'(1);
      if (drop && (dropCount != '1)) dropCount <= dropCount + STAT_W'(1);
    end
  end

  assign bus.inst_count  = instCount;
  assign bus.cycle_count = cycleCount;
  assign bus.drop_count  = dropCount;
`else
  assign bus.inst_count  = '0;
  assign bus.cycle_count = '0;
  assign bus.drop_count  = '0;
`endif

endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports RegWrite, MemRead, MemWrite, Halt  input  1 each  per-cycle commit event flags from processor.
REQ-005 SHALL have port WriteRegister  input  3  destination register of RegWrite.
REQ-006 SHALL have ports WriteData, MemAddress, MemDataIn, MemDataOut  input  16 each  register data, memory address, store data, load data.
REQ-007 SHALL have port trc_valid  output  1  head record available.
REQ-008 SHALL have port trc_ready  input  1  consumer accepts head record.
REQ-009 SHALL have port trc_data  output  55  head record {halt, regw, memr, memw, wreg[2:0], wdata[15:0], maddr[15:0], mdata[15:0]}, MSB first.
REQ-010 SHALL have ports full, overflow, done  output  1 each  FIFO full, sticky drop flag, halted-and-drained.
REQ-011 SHALL have ports inst_count, cycle_count, drop_count  output  32 each  statistics.

Function
REQ-012 SHALL form an event in any cycle where RegWrite|MemRead|MemWrite|Halt is 1; cycles with all four 0 SHALL NOT enqueue.
REQ-013 SHALL set record mdata to MemDataOut when MemRead=1, MemDataIn when MemWrite=1, 0 otherwise; MemRead and MemWrite both 1 SHALL select MemDataIn.
REQ-014 SHALL hold state machine CAPTURE -> HALTED on enqueue (or drop) of a record with halt=1; HALTED -> DONE when FIFO empty; DONE stays until reset.
REQ-015 SHALL ignore all events (no enqueue, no drop count) in HALTED and DONE.
REQ-016 SHALL write an accepted event into the FIFO at the posedge of its cycle; trc_valid SHALL rise the following cycle (latency 1) when FIFO was empty.
REQ-017 SHALL dequeue the head on posedge when trc_valid & trc_ready; trc_data SHALL be stable while trc_valid=1 and trc_ready=0.
REQ-018 SHALL accept a push when full if a pop occurs in the same cycle; count stays DEPTH.
REQ-019 SHALL drop an event when full with no same-cycle pop: overflow set (sticky), drop_count +1 saturating at 0xFFFFFFFF.
REQ-020 SHALL drop a halt event per REQ-019 yet still enter HALTED.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; full = (count==DEPTH), trc_valid = (count!=0).
REQ-022 SHALL assert done combinationally from state==DONE.
REQ-023 SHALL increment cycle_count every cycle in CAPTURE, freezing in HALTED/DONE.
REQ-024 SHALL increment inst_count on each event in CAPTURE with Halt|RegWrite|MemWrite (accepted or dropped).
REQ-025 SHALL wrap cycle_count and inst_count modulo 2^32.

Reset
REQ-026 SHALL on rst=1 immediately clear pointers, count, overflow, all counters, and enter CAPTURE; trc_valid, full, overflow, done = 0, trc_data = 0.
REQ-027 SHALL discard FIFO contents on reset mid-operation, including during HALTED or an in-flight stalled pop.
REQ-028 SHALL not capture an event presented in the cycle rst deasserts unless rst is 0 at that posedge.

Configuration
REQ-029 SHALL with TRACE_STATS_EN defined implement inst_count, cycle_count, drop_count per REQ-019/023/024.
REQ-030 SHALL without TRACE_STATS_EN tie inst_count, cycle_count, drop_count to 0 and omit their registers; overflow flag still implemented.

Verification
REQ-031 SHALL cover: RegWrite=1, WriteRegister=3, WriteData=0x1234, trc_ready=1 -> next cycle trc_valid=1, trc_data regw=1, wreg=3, wdata=0x1234, mdata=0.
REQ-032 SHALL cover: MemRead=1, MemAddress=0x0040, MemDataOut=0xBEEF, MemDataIn=0x1111 -> record memr=1, maddr=0x0040, mdata=0xBEEF.
REQ-033 SHALL cover: trc_ready=0, 10 consecutive RegWrite events, DEPTH=8 -> full=1 after 8, overflow=1, drop_count=2, inst_count=10; drain yields 8 records in order.
REQ-034 SHALL cover: full FIFO, push with simultaneous pop -> no drop, count remains 8, overflow=0.
REQ-035 SHALL cover: Halt=1 with 3 queued records, trc_ready=1 -> events after halt ignored, done=1 the cycle after 4th record popped, cycle_count frozen.
REQ-036 SHALL cover: rst pulsed while HALTED with 2 queued -> trc_valid=0, done=0, all counters 0 immediately, capture resumes after rst deasserts.
